// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - valid/ready seven-segment controller, hex or double-dabble decimal
// Optional blinking of the whole display is enabled with the SEG_BLINK_EN macro.
module seg_display_ctrl #(
  parameter int N_DIGITS  = 2,
  parameter int DATA_W    = 8,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_dec,
  input  logic                    in_blank_lz,
`ifdef SEG_BLINK_EN
  input  logic                    blink,
`endif
  output logic [8*N_DIGITS-1:0]   HEX,
  output logic                    overflow
);

  localparam int ND   = (3 * DATA_W + 9) / 10 + 1;
  localparam int BW   = 4 * ND;
  localparam int CNTW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t                  state;
  logic [DATA_W-1:0]       data_q;
  logic [BW-1:0]           bcd_q;
  logic [CNTW-1:0]         cnt;
  logic                    dec_q;
  logic                    blank_q;
  logic [8*N_DIGITS-1:0]   disp;

  logic [BW-1:0]           adj;
  logic [BW-1:0]           bcd_shift;
  logic [4*N_DIGITS+DATA_W-1:0] hex_ext;
  logic [4*N_DIGITS+BW-1:0]     bcd_ext;
  logic [N_DIGITS-1:0]     nz;
  logic [8*N_DIGITS-1:0]   disp_next;
  logic                    ovf_next;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  // Double-dabble step: add 3 to every BCD digit >= 5, then shift in the next data MSB.
  for (genvar j = 0; j < ND; j++) begin : g_adj
    assign adj[4*j +: 4] = (bcd_q[4*j +: 4] >= 4'd5) ? bcd_q[4*j +: 4] + 4'd3 : bcd_q[4*j +: 4];
  end
  assign bcd_shift = {adj[BW-2:0], data_q[DATA_W-1]};

  // Zero-padding lets every display digit index both sources even when they are narrower.
  assign hex_ext  = {{(4*N_DIGITS){1'b0}}, data_q};
  assign bcd_ext  = {{(4*N_DIGITS){1'b0}}, bcd_q};
  assign ovf_next = dec_q ? |bcd_ext[4*N_DIGITS +: BW] : |hex_ext[4*N_DIGITS +: DATA_W];

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    logic [3:0] dig;
    logic       shown;
    assign dig   = dec_q ? bcd_ext[4*i +: 4] : hex_ext[4*i +: 4];
    assign nz[i] = (dig != 4'd0);
    assign shown = (i == 0) || (|nz[N_DIGITS-1:i]) || !blank_q;
    assign disp_next[8*i +: 8] = ovf_next ? 8'hBF : (shown ? glyph(dig) : 8'hFF);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      disp     <= '1;
      overflow <= 1'b0;
      data_q   <= '0;
      bcd_q    <= '0;
      cnt      <= '0;
      dec_q    <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            dec_q    <= in_dec;
            blank_q  <= in_blank_lz;
            bcd_q    <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= in_dec ? CONV : LOAD;
          end
        end
        CONV: begin
          bcd_q  <= bcd_shift;
          data_q <= data_q << 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNTW'(DATA_W - 1)) state <= LOAD;
        end
        LOAD: begin
          disp     <= disp_next;
          overflow <= ovf_next;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BCW-1:0] blink_cnt;
  logic           phase;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign HEX = (blink && phase) ? '1 : disp;
`else
  assign HEX = disp;
`endif

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - scoreboard bench for seg_display_ctrl (N_DIGITS=2, DATA_W=8)
module tb_seg_display_ctrl;

  localparam int N  = 2;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_dec = 1'b0;
  logic          in_blank_lz = 1'b0;
  logic [8*N-1:0] HEX;
  logic          overflow;
`ifdef SEG_BLINK_EN
  logic          blink = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] hex;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  logic [7:0] glyph_t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 CLK = ~CLK;

  seg_display_ctrl #(
    .N_DIGITS (N),
    .DATA_W   (DW)
`ifdef SEG_BLINK_EN
    , .BLINK_DIV(4)
`endif
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_dec      (in_dec),
    .in_blank_lz (in_blank_lz),
`ifdef SEG_BLINK_EN
    .blink       (blink),
`endif
    .HEX         (HEX),
    .overflow    (overflow)
  );

  // Posedges since reset release; the blink phase is a pure function of this count.
  int edges;
  always @(posedge CLK or posedge RST) begin
    if (RST) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int v, input bit dec, input bit blz);
    exp_t e;
    int   base;
    int   p;
    int   dg [N];
    bit   seen;
    base  = dec ? 10 : 16;
    p     = 1;
    seen  = 0;
    for (int i = 0; i < N; i++) begin
      dg[i] = (v / p) % base;
      p     = p * base;
    end
    e.ovf = (v >= p);
    e.lat = dec ? DW + 1 : 1;
    e.hex = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dg[i] != 0 || i == 0) seen = 1;
      e.hex[8*i +: 8] = e.ovf ? 8'hBF : ((seen || !blz) ? glyph_t[dg[i]] : 8'hFF);
    end
    return e;
  endfunction

  task automatic send(input logic [7:0] v, input bit dec, input bit blz, input bit poke);
    exp_t e;
    int   n;
    @(negedge CLK);
    check("ready_before", {31'b0, in_ready}, 32'd1);
    in_data     = v;
    in_dec      = dec;
    in_blank_lz = blz;
    in_valid    = 1'b1;
    sb.push_back(model(v, dec, blz));
    @(negedge CLK);
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 200) begin
      if (poke && n == 3) begin
        in_valid = 1'b1;
        in_data  = 8'd11;
        in_dec   = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge CLK);
      n++;
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    check($sformatf("latency_%0d", v), n, e.lat);
    check($sformatf("hex_%0d_dec%0d_blz%0d", v, dec, blz), {16'b0, HEX}, {16'b0, e.hex});
    check($sformatf("ovf_%0d_dec%0d", v, dec), {31'b0, overflow}, {31'b0, e.ovf});
  endtask

  initial begin
    #12;
    check("rst_hex",   {16'b0, HEX},      32'h0000FFFF);
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    check("rst_ovf",   {31'b0, overflow}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    send(8'h3A, 0, 0, 0);
    send(8'd75, 1, 0, 1);
    send(8'd200, 1, 0, 0);
    send(8'h05, 0, 0, 0);
    send(8'd5, 1, 1, 0);
    send(8'd5, 1, 0, 0);
    send(8'h00, 0, 1, 0);
    send(8'hFF, 0, 1, 0);
    send(8'd99, 1, 1, 0);
    send(8'd100, 1, 1, 0);
    send(8'd0, 1, 1, 0);
    send(8'd10, 1, 1, 0);
    send(8'h10, 0, 1, 0);
    for (int k = 0; k < 6; k++)
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

    // Asynchronous reset mid-cycle from a lit display.
    send(8'h3A, 0, 0, 0);
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    check("async_rst_hex",   {16'b0, HEX},      32'h0000FFFF);
    check("async_rst_ready", {31'b0, in_ready}, 32'd1);
    check("async_rst_ovf",   {31'b0, overflow}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Reset during a decimal conversion discards the value.
    send(8'h3A, 0, 0, 0);
    @(negedge CLK);
    in_data  = 8'd75;
    in_dec   = 1'b1;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (DW + 3) @(negedge CLK);
    check("abort_hex",   {16'b0, HEX},      32'h0000FFFF);
    check("abort_ready", {31'b0, in_ready}, 32'd1);
    send(8'h3A, 0, 0, 0);

`ifdef SEG_BLINK_EN
    blink = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      check($sformatf("blink_on_%0d", k), {16'b0, HEX},
            (((edges / 4) % 2) == 1) ? 32'h0000FFFF : 32'h0000B088);
    end
    blink = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      check($sformatf("blink_off_%0d", k), {16'b0, HEX}, 32'h0000B088);
    end
`endif

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
